alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_cmd_fifo.sv | 69 ++++++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encoding and ALU function codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } alu_fun_t;

  localparam int FUN_BITS = 2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command FIFO for the ALU sequencer; entries are {fun, a, b} and the pointers
// wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [2*WIDTH+FUN_BITS-1:0] push_data,
  input  logic                        pop,
  output logic [2*WIDTH+FUN_BITS-1:0] pop_data,
  output logic                        full,
  output logic                        empty
);

  localparam int ENTRY_W = 2*WIDTH + FUN_BITS;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, issues them one at a time to an external arithmetic unit and returns each
// result on a ready/valid channel. Define ALU_SEQ_DIV0_CHECK_EN to answer divide-by-zero locally.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [WIDTH-1:0]   cmd_A,
  input  logic signed [WIDTH-1:0]   cmd_B,
  input  logic [1:0]                cmd_FUN,
  output logic signed [WIDTH-1:0]   A,
  output logic signed [WIDTH-1:0]   B,
  output logic [1:0]                ALU_FUN,
  output logic                      Arith_Enable,
  input  logic signed [2*WIDTH-1:0] Arith_OUT,
  input  logic                      Carry_OUT,
  input  logic                      Arith_Flag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic signed [2*WIDTH-1:0] rsp_data,
  output logic                      rsp_carry,
  output logic                      rsp_err
);

  localparam int ENTRY_W = 2*WIDTH + FUN_BITS;

  seq_state_t         state_q, state_d;
  logic [ENTRY_W-1:0] op_q, op_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] head;
  logic               head_div0;
  logic               start_next;
  logic               unused_arith_flag;

  assign unused_arith_flag = Arith_Flag;
  assign cmd_ready         = !fifo_full;

  alu_cmd_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .push     (cmd_valid && cmd_ready),
    .push_data({cmd_FUN, cmd_A, cmd_B}),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef ALU_SEQ_DIV0_CHECK_EN
  logic rsp_err_q, rsp_err_d;
  assign head_div0 = (head[ENTRY_W-1 -: FUN_BITS] == DIV) && (head[WIDTH-1:0] == '0);
  assign rsp_err   = rsp_err_q;
`else
  assign head_div0 = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // The head is popped either from IDLE or when the current response is consumed.
  assign start_next = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    fifo_pop    = 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    if (start_next) begin
      state_d = IDLE;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        if (head_div0) begin
          state_d     = RESP;
          rsp_data_d  = '0;
          rsp_carry_d = 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
          rsp_err_d   = 1'b1;
`endif
        end else begin
          state_d = ISSUE;
          op_d    = head;
        end
      end
    end
    case (state_q)
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        state_d     = RESP;
        rsp_data_d  = Arith_OUT;
        rsp_carry_d = Carry_OUT;
`ifdef ALU_SEQ_DIV0_CHECK_EN
        rsp_err_d   = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

`ifdef ALU_SEQ_DIV0_CHECK_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

  // Operands come straight from the operand register so they hold outside ISSUE.
  assign A            = op_q[2*WIDTH-1:WIDTH];
  assign B            = op_q[WIDTH-1:0];
  assign ALU_FUN      = op_q[ENTRY_W-1 -: FUN_BITS];
  assign Arith_Enable = (state_q == ISSUE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;

endmodule
